pipe_delay_reg_bank: RTL and testbench

- Parametrised successor to the single-stage enable/preset/tri-state register used in the pipeline datapath.
- Implements an NrOfStages-deep, NrOfBits-wide delay line for carrying control/data fields (e.g. RegWrite, rd, ALU result) across pipeline stages.
- Each stage carries a valid tag. Adds stall, flush, preset and occupancy tracking.
- Output is tri-stated by chip-select so several banks can share one bus.

---
 rtl/pipe_delay_reg_bank_if.sv | 23 ++
 rtl/pipe_delay_reg_bank.sv | 79 +++++++
 tb/tb_pipe_delay_reg_bank.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_delay_reg_bank_if.sv
// pipe_delay_reg_bank_if: control/data inputs and occupancy of one delay-line bank
interface pipe_delay_reg_bank_if #(
  parameter int NrOfBits = 8,
  parameter int CntBits  = 2
);
  logic                ClockEnable;
  logic                Tick;
  logic [NrOfBits-1:0] D;
  logic                DValid;
  logic                Stall;
  logic                Flush;
  logic                pre;
  logic                cs;
  logic [CntBits-1:0]  Occupancy;
  modport master (
    output ClockEnable, Tick, D, DValid, Stall, Flush, pre, cs,
    input  Occupancy
  );
  modport slave (
    input  ClockEnable, Tick, D, DValid, Stall, Flush, pre, cs,
    output Occupancy
  );
endinterface

// File: rtl/pipe_delay_reg_bank.sv
// pipe_delay_reg_bank: valid-tagged pipeline delay line with stall/flush/preset, tri-state output; PIPE_BUBBLE_COLLAPSE_EN closes bubbles under stall
module pipe_delay_reg_bank #(
  parameter int NrOfBits   = 8,
  parameter int NrOfStages = 3,
  parameter int CntBits    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  pipe_delay_reg_bank_if.slave  bus,
  output logic [NrOfBits-1:0]   Q,
  output logic                  QValid
);
  logic [NrOfBits-1:0]   data_q [NrOfStages];
  logic [NrOfBits-1:0]   data_d [NrOfStages];
  logic [NrOfStages-1:0] vld_q, vld_d;
  logic [CntBits-1:0]    occ_q, occ_d;
  logic                  ce, adv;
  assign ce  = bus.ClockEnable & bus.Tick;
  assign adv = ce & ~bus.Stall;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
  // nxt_vld[i] is the valid tag of stage i+1; the last stage sees a permanent "occupied" successor so it never leaves under stall
  logic [NrOfStages-1:0] nxt_vld;
  assign nxt_vld = NrOfStages'({1'b1, vld_q} >> 1);
`endif
  // next state: flush beats preset beats advance; everything else holds
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (ce && bus.Flush) begin
      vld_d = '0;
      occ_d = '0;
    end else if (ce && bus.pre) begin
      for (int i = 0; i < NrOfStages; i++) data_d[i] = '1;
      vld_d = '1;
      occ_d = CntBits'(NrOfStages);
    end else if (adv) begin
      data_d[0] = bus.D;
      vld_d[0]  = bus.DValid;
      for (int i = 1; i < NrOfStages; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      occ_d = occ_q + CntBits'(bus.DValid) - CntBits'(vld_q[NrOfStages-1]);
    end
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    else if (ce) begin
      for (int i = NrOfStages - 1; i >= 1; i--) begin
        if (!vld_q[i]) begin
          data_d[i] = data_q[i-1];
          vld_d[i]  = vld_q[i-1];
        end else if (!nxt_vld[i]) begin
          vld_d[i] = 1'b0;
        end
      end
      if (!vld_q[0] || !nxt_vld[0]) begin
        data_d[0] = bus.D;
        vld_d[0]  = bus.DValid;
        occ_d     = occ_q + CntBits'(bus.DValid);
      end
    end
`endif
  end
  // stage, valid-tag and occupancy registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      data_q <= '{default: '0};
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end
  assign Q             = bus.cs ? {NrOfBits{1'bz}} : data_q[NrOfStages-1];
  assign QValid        = bus.cs ? 1'bz : vld_q[NrOfStages-1];
  assign bus.Occupancy = occ_q;
endmodule

// File: tb/tb_pipe_delay_reg_bank.sv
// tb_pipe_delay_reg_bank: directed vector table plus randomized run against a queue-based model
module tb_pipe_delay_reg_bank;
  localparam int W = 8;
  localparam int N = 3;
  localparam int C = 2;

  typedef struct {
    logic r, ce, tk;
    logic [W-1:0] d;
    logic dv, st, fl, pr, cs, z;
    logic [W-1:0] q;
    logic qv;
    logic [C-1:0] occ;
  } vec_t;

  typedef struct packed {
    logic v;
    logic [W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] q;
  logic qv;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  ent_t m[$];

  always #5 clk = ~clk;

  pipe_delay_reg_bank_if #(.NrOfBits(W), .CntBits(C)) bus ();

  pipe_delay_reg_bank #(.NrOfBits(W), .NrOfStages(N), .CntBits(C)) dut (
    .Clock(clk), .Reset(rst), .bus(bus.slave), .Q(q), .QValid(qv)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // a released bus reads as Z, or as 0 where the simulator has no Z state
  task automatic chk_z(input string name);
    checks++;
    if (!((q === {W{1'bz}} || q === '0) && (qv === 1'bz || qv === 1'b0))) begin
      errors++;
      $display("FAIL %s got %0h/%0b want high-Z", name, q, qv);
    end
  endtask

  task automatic drive(input logic r, ce, tk, input logic [W-1:0] d,
                       input logic dv, st, fl, pr, cs);
    rst = r;
    bus.ClockEnable = ce;
    bus.Tick = tk;
    bus.D = d;
    bus.DValid = dv;
    bus.Stall = st;
    bus.Flush = fl;
    bus.pre = pr;
    bus.cs = cs;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic r, ce, tk, input logic [W-1:0] d,
                             input logic dv, st, fl, pr, cs, z,
                             input logic [W-1:0] eq, input logic eqv, input logic [C-1:0] eocc);
    vec_t t;
    t.r = r; t.ce = ce; t.tk = tk; t.d = d; t.dv = dv; t.st = st;
    t.fl = fl; t.pr = pr; t.cs = cs; t.z = z; t.q = eq; t.qv = eqv; t.occ = eocc;
    return t;
  endfunction

  function automatic int popcount();
    int n = 0;
    foreach (m[i]) n += int'(m[i].v);
    return n;
  endfunction

  // reference: the bank is a fixed-length queue, front = stage 0, back = output stage
  task automatic model_step(input logic r, ce, tk, input logic [W-1:0] d,
                            input logic dv, st, fl, pr);
    ent_t o[$];
    if (r) begin
      m = {};
      for (int i = 0; i < N; i++) m.push_back('0);
    end else if (ce && tk) begin
      if (fl) begin
        foreach (m[i]) m[i].v = 1'b0;
      end else if (pr) begin
        foreach (m[i]) m[i] = {1'b1, {W{1'b1}}};
      end else if (!st) begin
        m.push_front({dv, d});
        void'(m.pop_back());
      end
`ifdef PIPE_BUBBLE_COLLAPSE_EN
      else begin
        o = m;
        for (int i = N - 1; i >= 1; i--) begin
          if (!o[i].v) m[i] = o[i-1];
          else if (i < N - 1 && !o[i+1].v) m[i].v = 1'b0;
        end
        if (!o[0].v || (N > 1 && !o[1].v)) m[0] = {dv, d};
      end
`endif
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(v(1, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 1, 8'h11, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 1, 8'h22, 1, 0, 0, 0, 0, 0, 8'h00, 0, 2));
    tbl.push_back(v(0, 1, 1, 8'h33, 1, 0, 0, 0, 0, 0, 8'h11, 1, 3));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 1, 1, 8'h44, 1, 1, 0, 0, 0, 0, 8'h11, 1, 3));
    tbl.push_back(v(0, 1, 1, 8'h44, 1, 0, 0, 0, 0, 0, 8'h22, 1, 3));
    tbl.push_back(v(0, 1, 1, 8'h77, 1, 1, 1, 1, 0, 0, 8'h22, 0, 0));
    tbl.push_back(v(0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFF, 1, 3));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 1, 0, (i % 2 == 1) ? 8'hA5 : 8'h5A, 1, 0, i == 1, i == 3, 0, 0, 8'hFF, 1, 3));
    tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 8'h00, 0, 3));
    tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFF, 1, 3));
    tbl.push_back(v(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFF, 1, 2));
    tbl.push_back(v(1, 1, 1, 8'h99, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 1, 8'h55, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h55, 1, 1));

    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].ce, tbl[k].tk, tbl[k].d, tbl[k].dv, tbl[k].st, tbl[k].fl, tbl[k].pr, tbl[k].cs);
      if (tbl[k].z) begin
        chk_z($sformatf("vec%0d_hiz", k));
      end else begin
        chk($sformatf("vec%0d_q", k), 32'(q), 32'(tbl[k].q));
        chk($sformatf("vec%0d_qvalid", k), 32'(qv), 32'(tbl[k].qv));
      end
      chk($sformatf("vec%0d_occ", k), 32'(bus.Occupancy), 32'(tbl[k].occ));
    end

    for (int k = 0; k < 600; k++) begin
      logic r, ce, tk, dv, st, fl, pr, cs;
      logic [W-1:0] d;
      r  = (k == 0) || ($urandom_range(49) == 0);
      ce = $urandom_range(9) != 0;
      tk = $urandom_range(4) != 0;
      d  = W'($urandom);
      dv = $urandom_range(3) != 0;
      st = $urandom_range(3) == 0;
      fl = $urandom_range(19) == 0;
      pr = $urandom_range(24) == 0;
      cs = $urandom_range(7) == 0;
      drive(r, ce, tk, d, dv, st, fl, pr, cs);
      model_step(r, ce, tk, d, dv, st, fl, pr);
      chk($sformatf("rnd%0d_occ", k), 32'(bus.Occupancy), 32'(popcount()));
      if (cs) begin
        chk_z($sformatf("rnd%0d_hiz", k));
      end else begin
        chk($sformatf("rnd%0d_q", k), 32'(q), 32'(m[N-1].d));
        chk($sformatf("rnd%0d_qvalid", k), 32'(qv), 32'(m[N-1].v));
      end
    end

`ifdef PIPE_BUBBLE_COLLAPSE_EN
    drive(1, 1, 1, 8'h00, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 8'hAA, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 8'h00, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 8'hBB, 1, 0, 0, 0, 0);
    chk("collapse_pre_occ", 32'(bus.Occupancy), 32'd2);
    drive(0, 1, 1, 8'h66, 1, 1, 0, 0, 0);
    chk("collapse_q", 32'(q), 32'hAA);
    chk("collapse_qvalid", 32'(qv), 32'd1);
    chk("collapse_occ", 32'(bus.Occupancy), 32'd3);
    drive(0, 1, 1, 8'h00, 0, 0, 0, 0, 0);
    chk("collapse_moved_q", 32'(q), 32'hBB);
    drive(0, 1, 1, 8'h00, 0, 0, 0, 0, 0);
    chk("collapse_d_q", 32'(q), 32'h66);
    chk("collapse_d_qvalid", 32'(qv), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
